// File: rtl/uart_sched_pkg.sv
// Shared types and defaults for the UART message scheduler.
// The state encoding is fixed so the debug port can be decoded directly.
package uart_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        START = 2'd2,
        WAIT  = 2'd3
    } sched_state_t;

    localparam logic [7:0] DEF_TERM_CHAR = 8'h0A;
    localparam int         DEF_MAX_LEN   = 16;

    // Index width that stays legal for a single-source build.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: searches upward from last_grant+1 and wraps,
// so the previous winner is considered last.
module rr_arbiter
    import uart_sched_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int IW      = idx_width(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IW-1:0]      last_grant,
    output logic [NUM_SRC-1:0] winner,
    output logic               valid
);

    logic [IW-1:0] cand;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = IW'((int'(last_grant) + k) % NUM_SRC);
            if (!valid && req[cand]) begin
                winner[cand] = 1'b1;
                valid        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_msg_scheduler.sv
// Shares one UART TX between NUM_SRC ASCII sources: arbitrates round-robin and
// streams the winner's message byte by byte until the terminator or MAX_LEN.
module uart_msg_scheduler
    import uart_sched_pkg::*;
#(
    parameter int NUM_SRC    = 3,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int MAX_LEN    = DEF_MAX_LEN,
    parameter logic [DATA_WIDTH-1:0] TERM_CHAR = DATA_WIDTH'(DEF_TERM_CHAR)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC-1:0]            req,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    output logic [ADDR_WIDTH-1:0]         char_idx,
    output logic [NUM_SRC-1:0]            grant,
    output logic [NUM_SRC-1:0]            done,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_start,
    input  logic                          tx_busy,
    input  logic                          tx_done,
    output logic                          busy,
    output logic [1:0]                    state_dbg
);

    localparam int IW = idx_width(NUM_SRC);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(MAX_LEN - 1);

    sched_state_t              state, state_nxt;
    logic [NUM_SRC-1:0]        grant_nxt, done_nxt;
    logic [ADDR_WIDTH-1:0]     char_idx_nxt;
    logic [DATA_WIDTH-1:0]     tx_data_nxt, granted_char;
    logic                      tx_start_nxt;
    logic [IW-1:0]             last_grant, last_grant_nxt, grant_idx;
    logic [NUM_SRC-1:0]        arb_winner;
    logic                      arb_valid;

    rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .IW      (IW)
    ) u_arb (
        .req        (req),
        .last_grant (last_grant),
        .winner     (arb_winner),
        .valid      (arb_valid)
    );

    // Index and character of the current owner; grant is one-hot or zero.
    always_comb begin
        grant_idx    = '0;
        granted_char = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant[i]) begin
                grant_idx    = IW'(i);
                granted_char = src_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // UART handshake: tx_start is a one-cycle request that is only issued while
    // tx_busy is low; the byte is considered consumed on the tx_done pulse,
    // which is honoured only in WAIT.
    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        done_nxt       = '0;
        tx_start_nxt   = 1'b0;
        tx_data_nxt    = tx_data;
        char_idx_nxt   = char_idx;
        last_grant_nxt = last_grant;
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    grant_nxt    = arb_winner;
                    char_idx_nxt = '0;
                    state_nxt    = FETCH;
                end
            end
            FETCH: begin
                if (!tx_busy) begin
                    tx_data_nxt  = granted_char;
                    tx_start_nxt = 1'b1;
                    state_nxt    = START;
                end
            end
            START: state_nxt = WAIT;
            WAIT: begin
                if (tx_done) begin
                    if (tx_data == TERM_CHAR || char_idx == LAST_IDX) begin
                        done_nxt       = grant;
                        last_grant_nxt = grant_idx;
                        grant_nxt      = '0;
                        char_idx_nxt   = '0;
                        state_nxt      = IDLE;
                    end else begin
                        char_idx_nxt = char_idx + ADDR_WIDTH'(1);
                        state_nxt    = FETCH;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            grant      <= '0;
            done       <= '0;
            tx_start   <= 1'b0;
            tx_data    <= '0;
            char_idx   <= '0;
            last_grant <= IW'(NUM_SRC - 1);
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            done       <= done_nxt;
            tx_start   <= tx_start_nxt;
            tx_data    <= tx_data_nxt;
            char_idx   <= char_idx_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_uart_msg_scheduler.sv
// Bench for uart_msg_scheduler: directed scenarios with random message contents,
// a UART responder and a queue of expected {char_idx, byte} transfers.
module tb_uart_msg_scheduler;

    localparam int NS = 3;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int ML = 16;
    localparam int W  = AW + DW;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NS-1:0]   req = '0;
    logic [NS*DW-1:0] src_data;
    logic [AW-1:0]   char_idx;
    logic [NS-1:0]   grant, done;
    logic [DW-1:0]   tx_data;
    logic            tx_start, tx_busy, tx_done, busy;
    logic [1:0]      state_dbg;

    logic uart_busy = 1'b0, uart_done = 1'b0, force_busy = 1'b0, spur_done = 1'b0;
    int   uart_cnt = 0;

    logic [DW-1:0] mem [NS][ML];
    logic [W-1:0]  exp_q[$];
    int n_tests = 0, n_fail = 0, n_start = 0, n_done = 0, last_m = NS - 1;

    assign tx_busy = uart_busy | force_busy;
    assign tx_done = uart_done | spur_done;

    uart_msg_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .src_data  (src_data),
        .char_idx  (char_idx),
        .grant     (grant),
        .done      (done),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    // Sources answer combinationally from the shared index.
    always_comb begin
        src_data = '0;
        for (int s = 0; s < NS; s++) src_data[s*DW +: DW] = mem[s][char_idx];
    end

    // UART responder: busy for 10 cycles after tx_start, then a tx_done pulse.
    always @(negedge clk) begin
        uart_done = 1'b0;
        if (!rst) begin
            uart_busy = 1'b0;
            uart_cnt  = 0;
        end else if (tx_start) begin
            uart_busy = 1'b1;
            uart_cnt  = 10;
        end else if (uart_cnt > 0) begin
            uart_cnt--;
            if (uart_cnt == 0) begin
                uart_busy = 1'b0;
                uart_done = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard on every transfer.
    always @(negedge clk) begin
        chk("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
        if (tx_start) begin
            n_start++;
            chk("tx_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) chk("tx_idx_data", 32'({char_idx, tx_data}), 32'(exp_q.pop_front()));
        end
        if (done != '0) n_done++;
    end

    function automatic int rr_pick(input logic [NS-1:0] r, input int last);
        for (int k = 1; k <= NS; k++) begin
            if (r[(last + k) % NS]) return (last + k) % NS;
        end
        return 0;
    endfunction

    // Expected transfers of one message: up to and including 0A, at most ML bytes.
    function automatic int push_msg(input int s);
        int n = 0;
        for (int i = 0; i < ML; i++) begin
            exp_q.push_back({AW'(i), mem[s][i]});
            n++;
            if (mem[s][i] == 8'h0A) break;
        end
        return n;
    endfunction

    task automatic fill_rand(input int s, input int term);
        for (int i = 0; i < ML; i++) mem[s][i] = 8'($urandom_range(32, 126));
        if (term >= 0) mem[s][term] = 8'h0A;
    endtask

    task automatic start_msg(input logic [NS-1:0] r, output int s, output int cnt);
        logic [NS-1:0] g = '0;
        s = rr_pick(r, last_m);
        cnt = push_msg(s);
        n_start = 0;
        req = r;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (grant != '0) begin
                g = grant;
                break;
            end
        end
        chk("grant", 32'(g), 32'(1) << s);
        chk("busy_granted", 32'(busy), 32'd1);
    endtask

    task automatic finish_msg(input int s, input int cnt);
        logic [NS-1:0] d = '0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (done != '0) begin
                d = done;
                break;
            end
        end
        chk("done", 32'(d), 32'(1) << s);
        chk("grant_at_done", 32'(grant), 32'd0);
        chk("byte_count", 32'(n_start), 32'(cnt));
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        last_m = s;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_grant"}, 32'(grant), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_tx_start"}, 32'(tx_start), 32'd0);
        chk({tag, "_char_idx"}, 32'(char_idx), 32'd0);
        chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int s, cnt, nd;
        string dst;
        dst = "DST: 123cm\n";
        for (int i = 0; i < NS; i++) fill_rand(i, 5);

        // Reset values.
        repeat (3) @(negedge clk);
        chk_zero("reset");
        chk("reset_state", 32'(state_dbg), 32'(ST_IDLE));
        rst = 1'b1;
        @(negedge clk);
        chk("idle_no_req", 32'(busy), 32'd0);

        // Single message with timing of the first byte.
        for (int i = 0; i < ML; i++)
            mem[0][i] = (i < dst.len()) ? dst[i] : 8'($urandom_range(32, 126));
        cnt = push_msg(0);
        n_start = 0;
        req = 3'b001;
        @(negedge clk);
        chk("first_grant", 32'(grant), 32'h1);
        chk("first_busy", 32'(busy), 32'd1);
        chk("first_no_start", 32'(tx_start), 32'd0);
        chk("first_idx", 32'(char_idx), 32'd0);
        req = '0;
        @(negedge clk);
        chk("first_start", 32'(tx_start), 32'd1);
        chk("first_byte", 32'(tx_data), 32'h44);
        finish_msg(0, 11);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_after_done", 32'(busy), 32'd0);

        // Round-robin with all requests held from reset release.
        for (int i = 0; i < NS; i++) fill_rand(i, int'($urandom_range(3, 8)));
        rst = 1'b0;
        req = 3'b111;
        last_m = NS - 1;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            start_msg(3'b111, s, cnt);
            finish_msg(s, cnt);
        end
        req = '0;

        // Length limit: no terminator.
        fill_rand(1, -1);
        start_msg(3'b010, s, cnt);
        req = '0;
        finish_msg(s, cnt);
        chk("len_limit_bytes", 32'(n_start), 32'(ML));
        chk("len_limit_idx", 32'(char_idx), 32'd0);

        // tx_busy stall in FETCH.
        fill_rand(2, int'($urandom_range(2, 6)));
        force_busy = 1'b1;
        start_msg(3'b100, s, cnt);
        req = '0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_no_start", 32'(tx_start), 32'd0);
            chk("stall_fetch", 32'(state_dbg), 32'(ST_FETCH));
            @(negedge clk);
        end
        force_busy = 1'b0;
        @(negedge clk);
        chk("stall_released", 32'(tx_start), 32'd1);
        finish_msg(s, cnt);

        // Spurious tx_done in IDLE and in FETCH.
        @(negedge clk);
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        chk("spur_idle_state", 32'(state_dbg), 32'(ST_IDLE));
        chk("spur_idle_done", 32'(done), 32'd0);
        chk("spur_idle_grant", 32'(grant), 32'd0);
        fill_rand(0, 4);
        force_busy = 1'b1;
        start_msg(3'b001, s, cnt);
        req = '0;
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        chk("spur_fetch_state", 32'(state_dbg), 32'(ST_FETCH));
        chk("spur_fetch_idx", 32'(char_idx), 32'd0);
        chk("spur_fetch_done", 32'(done), 32'd0);
        force_busy = 1'b0;
        finish_msg(s, cnt);

        // Reset in the middle of a message.
        fill_rand(0, -1);
        start_msg(3'b001, s, cnt);
        req = '0;
        for (int i = 0; i < 200; i++) begin
            if (char_idx == AW'(4)) break;
            @(negedge clk);
        end
        chk("mid_reached_idx4", 32'(char_idx), 32'd4);
        nd = n_done;
        rst = 1'b0;
        #1;
        exp_q.delete();
        chk_zero("mid_reset");
        fill_rand(1, 5);
        req = 3'b010;
        last_m = NS - 1;
        @(negedge clk);
        chk_zero("mid_reset_hold");
        chk("mid_reset_no_done", 32'(n_done), 32'(nd));
        rst = 1'b1;
        start_msg(3'b010, s, cnt);
        req = '0;
        chk("restart_idx", 32'(char_idx), 32'd0);
        finish_msg(s, cnt);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
